// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: FIFO-buffered duty samples, one handed to the PWM
// generator per period_tick; primes before running, re-primes on underrun.
// Ports: clk, reset (async, active-high), enable, period_tick,
//   s_valid/s_data/s_ready (sample stream in),
//   duty/duty_update (to generator), fill (FIFO occupancy),
//   underrun_flag/clear_underrun/underrun_count (underrun status).
module pwm_duty_sequencer #(
  parameter int BIT_WIDTH = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int PRIME_LEVEL = 4,
  parameter logic [BIT_WIDTH-1:0] IDLE_DUTY =
    {1'b1, {(BIT_WIDTH-1){1'b0}}}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          period_tick,
  input  logic                          s_valid,
  input  logic [BIT_WIDTH-1:0]          s_data,
  output logic                          s_ready,
  output logic [BIT_WIDTH-1:0]          duty,
  output logic                          duty_update,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          underrun_flag,
  input  logic                          clear_underrun,
  output logic [15:0]                   underrun_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] PRIME_FILL = FW'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  logic push;
  logic pop;
  logic underrun;
  logic flush;

  // Ready depends only on registered state, so a pop in the same cycle
  // never frees a slot for a write at full.
  assign s_ready = (state != IDLE) && (fill < FULL);
  assign push = s_valid && s_ready;

  // IDLE holds the FIFO empty; dropping enable discards everything in
  // the same edge that takes the state to IDLE.
  assign flush = !enable || (state == IDLE);

  assign pop = enable && (state == RUN) && period_tick &&
               (fill != '0);
  assign underrun = enable && (state == RUN) && period_tick &&
                    (fill == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (enable) state_n = PRIME;
      end
      PRIME: begin
        if (fill >= PRIME_FILL) state_n = RUN;
      end
      RUN: begin
        if (underrun) state_n = PRIME;
      end
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end

  // Storage needs no reset: pointers and fill define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      duty        <= IDLE_DUTY;
      duty_update <= 1'b0;
    end else begin
      duty_update <= pop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
        duty   <= IDLE_DUTY;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          duty   <= mem[rd_ptr];
        end
        unique case ({push, pop})
          2'b10:   fill <= fill + FW'(1);
          2'b01:   fill <= fill - FW'(1);
          default: fill <= fill;
        endcase
      end
    end
  end

  // A new underrun outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_flag  <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (underrun) begin
        underrun_flag <= 1'b1;
      end else if (clear_underrun) begin
        underrun_flag <= 1'b0;
      end
      if (underrun && (underrun_count != 16'hFFFF)) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer.
// Drives inputs 1ns after each rising edge and checks there too.
module tb_pwm_duty_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        period_tick;
  logic        s_valid;
  logic [11:0] s_data;
  logic        s_ready;
  logic [11:0] duty;
  logic        duty_update;
  logic [3:0]  fill;
  logic        underrun_flag;
  logic        clear_underrun;
  logic [15:0] underrun_count;

  int total = 0;
  int bad = 0;

  pwm_duty_sequencer dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .period_tick(period_tick),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .duty(duty),
    .duty_update(duty_update),
    .fill(fill),
    .underrun_flag(underrun_flag),
    .clear_underrun(clear_underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] d);
    s_valid = 1'b1;
    s_data = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic tick();
    period_tick = 1'b1;
    step();
    period_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    period_tick = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    clear_underrun = 1'b0;
    step();
    step();
    total++;
    if (duty !== 12'h800) begin
      $display("FAIL rst_duty got=%h want=800", duty); bad++;
    end
    total++;
    if ({duty_update, fill, s_ready, underrun_flag} !== 7'd0) begin
      $display("FAIL rst_flags got=%b want=0",
               {duty_update, fill, s_ready, underrun_flag}); bad++;
    end
    total++;
    if (underrun_count !== 16'd0) begin
      $display("FAIL rst_cnt got=%0d want=0", underrun_count); bad++;
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_prime_run();
    logic [11:0] exp [4];
    exp = '{12'h100, 12'h200, 12'h300, 12'h400};
    enable = 1'b1;
    step();
    total++;
    if (s_ready !== 1'b1) begin
      $display("FAIL prime_ready got=%b want=1", s_ready); bad++;
    end
    for (int i = 0; i < 4; i++) wr(exp[i]);
    total++;
    if (fill !== 4'd4 || dut.state !== 2'd1) begin
      $display("FAIL prime_fill got=%0d/%0d want=4/1",
               fill, dut.state); bad++;
    end
    step();
    total++;
    if (dut.state !== 2'd2 || duty !== 12'h800) begin
      $display("FAIL run_entry got=%0d/%h want=2/800",
               dut.state, duty); bad++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (duty !== exp[i] || duty_update !== 1'b1 ||
          fill !== 4'(3 - i)) begin
        $display("FAIL pop%0d got=%h/%b/%0d want=%h/1/%0d",
                 i, duty, duty_update, fill, exp[i], 3 - i); bad++;
      end
      step();
      total++;
      if (duty_update !== 1'b0 || duty !== exp[i]) begin
        $display("FAIL pop%0d_hold got=%b/%h want=0/%h",
                 i, duty_update, duty, exp[i]); bad++;
      end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) wr(12'hA00 + 12'(i));
    total++;
    if (fill !== 4'd8 || s_ready !== 1'b0) begin
      $display("FAIL full got=%0d/%b want=8/0", fill, s_ready); bad++;
    end
    wr(12'hBAD);
    total++;
    if (fill !== 4'd8) begin
      $display("FAIL full_refuse got=%0d want=8", fill); bad++;
    end
    s_valid = 1'b1;
    s_data = 12'hBEE;
    tick();
    s_valid = 1'b0;
    total++;
    if (fill !== 4'd7 || duty !== 12'hA00) begin
      $display("FAIL full_tick got=%0d/%h want=7/a00", fill, duty); bad++;
    end
    for (int i = 1; i < 7; i++) tick();
    total++;
    if (fill !== 4'd1 || duty !== 12'hA06) begin
      $display("FAIL drain got=%0d/%h want=1/a06", fill, duty); bad++;
    end
  endtask

  task automatic test_underrun();
    tick();
    total++;
    if (duty !== 12'hA07 || fill !== 4'd0) begin
      $display("FAIL last got=%h/%0d want=a07/0", duty, fill); bad++;
    end
    tick();
    total++;
    if (duty !== 12'hA07 || duty_update !== 1'b0 ||
        underrun_flag !== 1'b1 || underrun_count !== 16'd1) begin
      $display("FAIL under got=%h/%b/%b/%0d want=a07/0/1/1",
               duty, duty_update, underrun_flag, underrun_count); bad++;
    end
    total++;
    if (dut.state !== 2'd1) begin
      $display("FAIL under_state got=%0d want=1", dut.state); bad++;
    end
    tick();
    tick();
    total++;
    if (duty !== 12'hA07 || underrun_count !== 16'd1) begin
      $display("FAIL prime_ign got=%h/%0d want=a07/1",
               duty, underrun_count); bad++;
    end
    for (int i = 1; i <= 4; i++) wr(12'hC00 + 12'(i));
    step();
    tick();
    total++;
    if (duty !== 12'hC01 || fill !== 4'd3) begin
      $display("FAIL reprime got=%h/%0d want=c01/3", duty, fill); bad++;
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) tick();
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    total++;
    if (underrun_flag !== 1'b1 || underrun_count !== 16'd2 ||
        duty !== 12'hC04) begin
      $display("FAIL set_wins got=%b/%0d/%h want=1/2/c04",
               underrun_flag, underrun_count, duty); bad++;
    end
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    total++;
    if (underrun_flag !== 1'b0 || underrun_count !== 16'd2) begin
      $display("FAIL clear got=%b/%0d want=0/2",
               underrun_flag, underrun_count); bad++;
    end
  endtask

  task automatic test_disable();
    for (int i = 1; i <= 5; i++) wr(12'hD00 + 12'(i));
    total++;
    if (fill !== 4'd5 || dut.state !== 2'd2) begin
      $display("FAIL pre_dis got=%0d/%0d want=5/2", fill, dut.state); bad++;
    end
    enable = 1'b0;
    step();
    total++;
    if (dut.state !== 2'd0 || fill !== 4'd0 ||
        duty !== 12'h800 || s_ready !== 1'b0) begin
      $display("FAIL disable got=%0d/%0d/%h/%b want=0/0/800/0",
               dut.state, fill, duty, s_ready); bad++;
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) wr(12'hE00 + 12'(i));
    step();
    tick();
    total++;
    if (duty !== 12'hE01 || fill !== 4'd3) begin
      $display("FAIL pre_rst got=%h/%0d want=e01/3", duty, fill); bad++;
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (duty !== 12'h800 || fill !== 4'd0 || s_ready !== 1'b0 ||
        underrun_count !== 16'd0 || dut.state !== 2'd0) begin
      $display("FAIL async_rst got=%h/%0d/%b/%0d/%0d want=800/0/0/0/0",
               duty, fill, s_ready, underrun_count, dut.state); bad++;
    end
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_prime_run();
    test_full();
    test_underrun();
    test_clear();
    test_disable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
